timer_sequencer: RTL and testbench

Control stage that drives a one-shot delay counter (load-on-enable, MSB-as-expiry-flag style) and consumes its expiry flag. It accepts a start request with a repeat count and reloads the counter once per expiry. It emits one tick per expiry and a done pulse after the last one. It also detects a counter that fails to arm.

---
 rtl/timer_sequencer.sv | 145 ++++++++++++++
 tb/tb_timer_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// Drives a one-shot delay counter through load/arm/run phases, ticking once per expiry and
// flagging a counter that never drops its expiry flag after a load. All outputs registered.
module timer_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_req,
    input  logic [CNT_W-1:0] i_repeat,
    input  logic             i_abort,
    output logic             o_start_ack,
    output logic             o_cnt_load,
    input  logic             i_cnt_flag,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ARM  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_repeat;
    logic [CNT_W-1:0] w_repeat_nxt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] w_tick_cnt_nxt;
    logic             r_arm_cnt;
    logic             w_arm_cnt_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [CNT_W-1:0] w_tick_inc;
    logic             w_last;

    assign w_tick_inc = r_tick_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // A zero repeat count means free-running: the run never reaches its last interval.
    assign w_last     = (r_repeat != '0) && (w_tick_inc == r_repeat);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_repeat_nxt   = r_repeat;
        w_tick_cnt_nxt = r_tick_cnt;
        w_arm_cnt_nxt  = r_arm_cnt;
        w_ack_nxt      = 1'b0;
        w_tick_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;

        if ((r_state != S_IDLE) && i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start_req && !i_abort) begin
                        w_repeat_nxt   = i_repeat;
                        w_tick_cnt_nxt = '0;
                        w_err_nxt      = 1'b0;
                        w_ack_nxt      = 1'b1;
                        w_state_nxt    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_arm_cnt_nxt = 1'b0;
                    w_state_nxt   = S_ARM;
                end
                S_ARM: begin
                    // The counter gets two samples to show it has armed before we give up.
                    if (!i_cnt_flag) begin
                        w_state_nxt = S_RUN;
                    end else if (r_arm_cnt) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_arm_cnt_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_cnt_flag) begin
                        w_tick_nxt     = 1'b1;
                        w_tick_cnt_nxt = w_tick_inc;
                        if (w_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_repeat   <= '0;
            r_tick_cnt <= '0;
            r_arm_cnt  <= 1'b0;
            r_ack      <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_repeat   <= w_repeat_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_arm_cnt  <= w_arm_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_tick     <= w_tick_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign o_start_ack = r_ack;
    assign o_cnt_load  = (r_state == S_LOAD);
    assign o_busy      = (r_state != S_IDLE);
    assign o_tick      = r_tick;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_tick_cnt  = r_tick_cnt;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: a countdown counter (load 49, MSB flag) plus a run-level model.
module tb_timer_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_start_req = 1'b0;
    logic [CNT_W-1:0] i_repeat = '0;
    logic             i_abort = 1'b0;
    logic             o_start_ack, o_cnt_load, o_busy, o_tick, o_done, o_err;
    logic [CNT_W-1:0] o_tick_cnt;
    logic             cnt_flag;
    logic             force_high = 1'b0;
    logic [7:0]       cnt = 8'h80;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    timer_sequencer #(.CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start_req(i_start_req), .i_repeat(i_repeat),
        .i_abort(i_abort), .o_start_ack(o_start_ack), .o_cnt_load(o_cnt_load),
        .i_cnt_flag(cnt_flag), .o_busy(o_busy), .o_tick(o_tick), .o_done(o_done),
        .o_err(o_err), .o_tick_cnt(o_tick_cnt)
    );

    always #5 clk = ~clk;

    // External one-shot counter: loads 49 and counts down until bit 7 sets, then holds.
    always @(posedge clk) begin
        if (o_cnt_load) cnt <= 8'd49;
        else if (!cnt[7]) cnt <= cnt - 8'd1;
    end
    assign cnt_flag = force_high | cnt[7];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
        end
    endtask

    // Run-level model: tracks whether a run is live, which phase of an interval it is in,
    // and how many expiries this run has seen.
    bit m_active = 0, m_loading = 0, m_arming = 0, m_err = 0;
    bit e_ack = 0, e_tick = 0, e_done = 0;
    int m_high = 0, m_repeat = 0, m_ticks = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        e_ack = 0; e_tick = 0; e_done = 0;
        if (rst) begin
            m_active = 0; m_loading = 0; m_arming = 0; m_err = 0;
            m_ticks = 0; m_repeat = 0; m_high = 0;
        end else if (!m_active) begin
            if (i_start_req && !i_abort) begin
                m_active = 1; m_loading = 1; m_ticks = 0; m_err = 0;
                m_repeat = int'(i_repeat); e_ack = 1;
            end
        end else if (i_abort) begin
            m_active = 0; m_loading = 0; m_arming = 0;
        end else if (m_loading) begin
            m_loading = 0; m_arming = 1; m_high = 0;
        end else if (m_arming) begin
            if (!cnt_flag) m_arming = 0;
            else begin
                m_high++;
                if (m_high == 2) begin
                    m_err = 1; m_active = 0; m_arming = 0;
                end
            end
        end else if (cnt_flag) begin
            e_tick = 1;
            m_ticks++;
            if (m_repeat != 0 && m_ticks == m_repeat) begin
                e_done = 1; m_active = 0;
            end else begin
                m_loading = 1;
            end
        end
    end

    int n_tick = 0, n_done = 0, n_ack = 0, n_load = 0, n_wrap = 0, n_err_rise = 0;
    int last_ack_cyc = 0, last_done_cyc = 0, err_rise_cyc = 0, prev_tc = 0, prev_err = 0;
    int tick_cyc[$];

    initial forever begin
        @(negedge clk);
        check("busy", int'(o_busy), int'(m_active));
        check("cnt_load", int'(o_cnt_load), int'(m_loading));
        check("start_ack", int'(o_start_ack), int'(e_ack));
        check("tick", int'(o_tick), int'(e_tick));
        check("done", int'(o_done), int'(e_done));
        check("err", int'(o_err), int'(m_err));
        check("tick_cnt", int'(o_tick_cnt), m_ticks & 255);
        if (o_tick) begin n_tick++; tick_cyc.push_back(cyc); end
        if (o_done) begin n_done++; last_done_cyc = cyc; end
        if (o_start_ack) begin n_ack++; last_ack_cyc = cyc; end
        if (o_cnt_load) n_load++;
        if (o_err && prev_err == 0) begin n_err_rise++; err_rise_cyc = cyc; end
        if (prev_tc == 255 && o_tick_cnt == 0) n_wrap++;
        prev_tc = int'(o_tick_cnt);
        prev_err = int'(o_err);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int rep);
        i_start_req = 1'b1;
        i_repeat = 8'(rep);
        nxt();
        i_start_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        for (int i = 0; i < budget && o_busy; i++) nxt();
        check(nm, int'(o_busy), 0);
    endtask

    task automatic wait_ticks(input int target, input int budget, input string nm);
        for (int i = 0; i < budget && n_tick < target; i++) nxt();
        check(nm, int'(n_tick >= target), 1);
    endtask

    task automatic basic_run(input string nm);
        int bi, ack_c;
        bi = tick_cyc.size();
        start(3);
        ack_c = cyc;
        check({nm, "_ack"}, int'(o_start_ack), 1);
        wait_idle(400, {nm, "_idle"});
        check({nm, "_ntick"}, tick_cyc.size() - bi, 3);
        if (tick_cyc.size() - bi == 3) begin
            check({nm, "_first_lat"}, tick_cyc[bi] - ack_c, 52);
            check({nm, "_gap1"}, tick_cyc[bi+1] - tick_cyc[bi], 52);
            check({nm, "_gap2"}, tick_cyc[bi+2] - tick_cyc[bi+1], 52);
            check({nm, "_done_on_last"}, last_done_cyc, tick_cyc[bi+2]);
        end
        check({nm, "_tick_cnt"}, int'(o_tick_cnt), 3);
    endtask

    initial begin
        int b_tick, b_done, b_ack, b_load, b_wrap, load_c;
        #1 rst = 1'b1;
        repeat (3) nxt();
        check("reset_busy", int'(o_busy), 0);
        check("reset_tick_cnt", int'(o_tick_cnt), 0);
        rst = 1'b0;
        nxt();

        basic_run("basic");
        nxt();

        // Counter that never arms.
        force_high = 1'b1;
        b_load = n_load;
        b_tick = n_tick;
        start(1);
        load_c = cyc;
        for (int i = 0; i < 10 && !o_err; i++) nxt();
        check("armfail_err", int'(o_err), 1);
        check("armfail_lat", err_rise_cyc - load_c, 3);
        check("armfail_busy", int'(o_busy), 0);
        check("armfail_loads", n_load - b_load, 1);
        check("armfail_ticks", n_tick - b_tick, 0);
        force_high = 1'b0;
        repeat (3) nxt();
        start(1);
        check("err_cleared", int'(o_err), 0);
        wait_idle(200, "rerun_idle");
        check("rerun_tick_cnt", int'(o_tick_cnt), 1);
        nxt();

        // Abort in LOAD, ARM and RUN-with-flag-high.
        start(4);
        i_abort = 1'b1;
        nxt();
        i_abort = 1'b0;
        check("abort_load_busy", int'(o_busy), 0);
        check("abort_load_tc", int'(o_tick_cnt), 0);
        nxt();
        start(4);
        nxt();
        i_abort = 1'b1;
        nxt();
        i_abort = 1'b0;
        check("abort_arm_busy", int'(o_busy), 0);
        nxt();
        b_tick = n_tick;
        b_done = n_done;
        start(5);
        wait_ticks(b_tick + 1, 200, "abort_run_first");
        repeat (51) nxt();
        check("abort_run_flag_high", int'(cnt_flag), 1);
        i_abort = 1'b1;
        nxt();
        i_abort = 1'b0;
        check("abort_run_busy", int'(o_busy), 0);
        check("abort_run_tick", int'(o_tick), 0);
        check("abort_run_tc", int'(o_tick_cnt), 1);
        check("abort_run_ntick", n_tick - b_tick, 1);
        check("abort_run_done", n_done - b_done, 0);
        nxt();

        // Request held high across two back-to-back runs.
        b_ack = n_ack;
        b_done = n_done;
        i_start_req = 1'b1;
        i_repeat = 8'd2;
        for (int i = 0; i < 500 && (n_ack - b_ack) < 2; i++) nxt();
        i_start_req = 1'b0;
        check("hs_two_acks", n_ack - b_ack, 2);
        check("hs_ack_after_done", last_ack_cyc, last_done_cyc + 1);
        wait_idle(300, "hs_idle");
        check("hs_acks_final", n_ack - b_ack, 2);
        check("hs_dones", n_done - b_done, 2);
        nxt();

        // Free-running for 260 intervals.
        b_tick = n_tick;
        b_done = n_done;
        b_wrap = n_wrap;
        start(0);
        wait_ticks(b_tick + 260, 14000, "free_ticks");
        i_abort = 1'b1;
        nxt();
        i_abort = 1'b0;
        check("free_busy", int'(o_busy), 0);
        check("free_tc", int'(o_tick_cnt), 4);
        check("free_wrap", n_wrap - b_wrap, 1);
        check("free_done", n_done - b_done, 0);
        b_load = n_load;
        repeat (60) nxt();
        check("free_no_load", n_load - b_load, 0);

        // Asynchronous reset between edges, mid-run.
        b_tick = n_tick;
        start(3);
        wait_ticks(b_tick + 1, 200, "rst_first_tick");
        repeat (10) nxt();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(o_busy), 0);
        check("arst_load", int'(o_cnt_load), 0);
        check("arst_ack", int'(o_start_ack), 0);
        check("arst_tick", int'(o_tick), 0);
        check("arst_done", int'(o_done), 0);
        check("arst_err", int'(o_err), 0);
        check("arst_tc", int'(o_tick_cnt), 0);
        repeat (2) nxt();
        rst = 1'b0;
        repeat (3) nxt();
        check("arst_stays_idle", int'(o_busy), 0);
        basic_run("restart");
        repeat (3) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
